// File: rtl/sr_cmd_conditioner.sv
// Conditions two raw, bouncy command lines into clean, mutually exclusive
// S/R pulses for a downstream SR flip-flop; reset requests win over set.
module sr_cmd_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PULSE_CYCLES    = 1,
  parameter int HOLDOFF_CYCLES  = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set_in,
  input  logic rst_in,
  output logic s_out,
  output logic r_out,
  output logic busy,
  output logic conflict
);

  localparam int DW   = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam int TMAX = (PULSE_CYCLES > HOLDOFF_CYCLES) ? PULSE_CYCLES : HOLDOFF_CYCLES;
  localparam int TW   = (TMAX < 2) ? 1 : $clog2(TMAX);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SET_P = 2'd1;
  localparam logic [1:0] RST_P = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  // Channel index 0 is set, index 1 is reset.
  logic [1:0]    sync1, sync2, db, rise, pend, clr;
  logic [DW-1:0] dcnt [2];
  logic [1:0]    state;
  logic [TW-1:0] tcnt;
  logic          pulse_done, hold_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {rst_in, set_in};
      sync2 <= sync1;
    end
  end

  // A rising edge is taken on the same edge the debounced level goes high,
  // so the request is visible to the arbiter on the following cycle.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      rise[i] = (sync2[i] != db[i]) && !db[i] && (dcnt[i] == DW'(DEBOUNCE_CYCLES - 1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db      <= '0;
      dcnt[0] <= '0;
      dcnt[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == db[i]) begin
          dcnt[i] <= '0;
        end else if (dcnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          db[i]   <= ~db[i];
          dcnt[i] <= '0;
        end else begin
          dcnt[i] <= dcnt[i] + DW'(1);
        end
      end
    end
  end

  // The arbiter consumes whatever is pending while IDLE; when both are
  // pending the set request is dropped along with the reset one.
  always_comb begin
    clr        = (state == IDLE) ? pend : 2'b00;
    pulse_done = (tcnt == TW'(PULSE_CYCLES - 1));
    hold_done  = (tcnt == TW'(HOLDOFF_CYCLES - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= '0;
    end else begin
      pend <= rise | (pend & ~clr);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      tcnt     <= '0;
      s_out    <= 1'b0;
      r_out    <= 1'b0;
      busy     <= 1'b0;
      conflict <= 1'b0;
    end else begin
      conflict <= 1'b0;
      case (state)
        IDLE: begin
          tcnt <= '0;
          if (pend[1]) begin
            state    <= RST_P;
            r_out    <= 1'b1;
            busy     <= 1'b1;
            conflict <= pend[0];
          end else if (pend[0]) begin
            state <= SET_P;
            s_out <= 1'b1;
            busy  <= 1'b1;
          end
        end
        SET_P, RST_P: begin
          if (pulse_done) begin
            tcnt  <= '0;
            s_out <= 1'b0;
            r_out <= 1'b0;
            if (HOLDOFF_CYCLES > 0) begin
              state <= HOLD;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        default: begin
          if (hold_done) begin
            tcnt  <= '0;
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
      endcase
    end
  end

endmodule
